// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit and the write-back mux
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [2:0] WB_LU = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RSP  = 2'b10,
        DONE = 2'b11
    } lsu_state_e;

    // Size 2'b11 is handled as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == SZ_HALF) ? off[0] : (size[1] ? |off : 1'b0);
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// load_align_ext: pick the addressed byte/half/word from a read word and extend it
module load_align_ext
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] result_o
);

    logic [4:0]  amt;
    logic [31:0] sh;

    // Shift the addressed lane down to bit 0, then zero- or sign-extend it.
    always_comb begin
        amt      = (size_i == SZ_HALF) ? {off_i[1], 4'b0000} : {off_i, 3'b000};
        sh       = rdata_i >> amt;
        result_o = (size_i == SZ_BYTE) ? {{24{~unsigned_i & sh[7]}}, sh[7:0]} :
                   (size_i == SZ_HALF) ? {{16{~unsigned_i & sh[15]}}, sh[15:0]} :
                   rdata_i;
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: stage-3 data-memory access, one valid/ready transaction per memory op
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_op_valid_in,
    input  logic            is_store_in,
    input  logic [XLEN-1:0] addr_in,
    input  logic [XLEN-1:0] store_data_in,
    input  logic [1:0]      load_size_in,
    input  logic            load_unsigned_in,
    output logic            dmem_req_valid_out,
    input  logic            dmem_req_ready_in,
    output logic [XLEN-1:0] dmem_addr_out,
    output logic            dmem_we_out,
    output logic [3:0]      dmem_wstrb_out,
    output logic [XLEN-1:0] dmem_wdata_out,
    input  logic            dmem_rsp_valid_in,
    input  logic [XLEN-1:0] dmem_rdata_in,
    output logic [XLEN-1:0] lu_output_out,
    output logic            lu_valid_out,
    output logic            stall_out,
    output logic            misaligned_out
);

    lsu_state_e      state_q, state_d;
    logic [1:0]      off_q, off_d, size_q, size_d;
    logic            uns_q, uns_d, store_q, store_d;
    logic            req_valid_q, req_valid_d, we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, lu_q, lu_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic [XLEN-1:0] ext;
    logic            mis, accept;

    assign mis    = is_misaligned(load_size_in, addr_in[1:0]);
    assign accept = (state_q == IDLE) && mem_op_valid_in && !mis;

    load_align_ext u_align (
        .rdata_i   (dmem_rdata_in),
        .off_i     (off_q),
        .size_i    (size_q),
        .unsigned_i(uns_q),
        .result_o  (ext)
    );

    // Next-state and request/result register updates for the access FSM.
    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;
        store_d     = store_q;
        req_valid_d = req_valid_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wstrb_d     = wstrb_q;
        wdata_d     = wdata_q;
        lu_d        = lu_q;
        case (state_q)
            IDLE: if (accept) begin
                off_d       = addr_in[1:0];
                size_d      = load_size_in;
                uns_d       = load_unsigned_in;
                store_d     = is_store_in;
                req_valid_d = 1'b1;
                we_d        = is_store_in;
                addr_d      = {addr_in[XLEN-1:2], 2'b00};
                wstrb_d     = !is_store_in ? 4'b0000 :
                              (load_size_in == SZ_BYTE) ? (4'b0001 << addr_in[1:0]) :
                              (load_size_in == SZ_HALF) ? (addr_in[1] ? 4'b1100 : 4'b0011) :
                              4'b1111;
                wdata_d     = (load_size_in == SZ_BYTE) ? {4{store_data_in[7:0]}} :
                              (load_size_in == SZ_HALF) ? {2{store_data_in[15:0]}} :
                              store_data_in;
                state_d     = REQ;
            end
            REQ: if (dmem_req_ready_in) begin
                req_valid_d = 1'b0;
                state_d     = store_q ? DONE : RSP;
            end
            RSP: if (dmem_rsp_valid_in) begin
                lu_d    = ext;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and register update; synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            off_q       <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            store_q     <= 1'b0;
            req_valid_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wstrb_q     <= '0;
            wdata_q     <= '0;
            lu_q        <= '0;
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            store_q     <= store_d;
            req_valid_q <= req_valid_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wstrb_q     <= wstrb_d;
            wdata_q     <= wdata_d;
            lu_q        <= lu_d;
        end
    end

    assign dmem_req_valid_out = req_valid_q;
    assign dmem_addr_out      = addr_q;
    assign dmem_we_out        = we_q;
    assign dmem_wstrb_out     = wstrb_q;
    assign dmem_wdata_out     = wdata_q;
    assign lu_output_out      = lu_q;
    assign lu_valid_out       = (state_q == DONE);
    assign stall_out          = !reset && ((state_q == REQ) || (state_q == RSP) || accept);
    assign misaligned_out     = !reset && (state_q == IDLE) && mem_op_valid_in && mis;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Stage-3 data-memory access unit. It sits directly downstream of the stage-2/3 pipeline register. It takes the registered effective address, store data, load size and load-unsigned flag, and runs one valid/ready transaction on the data-memory port per memory instruction. It returns the aligned, extended load result to the write-back mux (LU input). While a transaction is outstanding it stalls the pipeline.

## Interface
Parameters:
- XLEN, 32, data/address width; only 32 is supported.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  reset, synchronous, active-high.
- mem_op_valid_in  in  1  stage 3 holds a load or store this cycle.
- is_store_in  in  1  1 = store, 0 = load.
- addr_in  in  32  effective address (registered iadder output).
- store_data_in  in  32  store data (registered rs2).
- load_size_in  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- load_unsigned_in  in  1  zero-extend loads when 1, sign-extend when 0.
- dmem_req_valid_out  out  1  request valid.
- dmem_req_ready_in  in  1  memory accepts the request.
- dmem_addr_out  out  32  word-aligned address, {addr[31:2],2'b00}.
- dmem_we_out  out  1  write enable.
- dmem_wstrb_out  out  4  byte strobes.
- dmem_wdata_out  out  32  lane-replicated store data.
- dmem_rsp_valid_in  in  1  read data valid.
- dmem_rdata_in  in  32  read data word.
- lu_output_out  out  32  aligned/extended load result.
- lu_valid_out  out  1  one-cycle pulse when lu_output_out updates, or a store completes.
- stall_out  out  1  freezes stages 1–3.
- misaligned_out  out  1  one-cycle pulse when an access is misaligned.

## Operation
- FSM states: IDLE, REQ, RSP, DONE.
- **IDLE, mem_op_valid_in=1, aligned access:**
  - Latch the offset addr[1:0], the size, the unsigned flag and is_store.
  - Drive the dmem_* request registers.
  - Move to REQ.
- **IDLE, misaligned access** (half with addr[0]=1, or word with addr[1:0]≠0):
  - Pulse misaligned_out for 1 cycle.
  - Issue no request and do not stall; stay in IDLE.
  - Take no further action until the pipeline presents a new instruction.
- **REQ:**
  - dmem_req_valid_out=1.
  - Address, we, wstrb and wdata stay stable until dmem_req_ready_in=1.
  - On ready: a store goes to DONE; a load goes to RSP.
  - dmem_req_valid_out drops on the next edge.
- **RSP:** on dmem_rsp_valid_in, register the extracted result into lu_output_out and go to DONE. dmem_rsp_valid_in is ignored in every state except RSP.
- **DONE:** lu_valid_out=1 and stall_out=0, so the pipeline advances. Next state is IDLE.
- **stall_out (combinational):**
  - 1 in REQ and RSP.
  - 1 in IDLE when mem_op_valid_in is high and the access is aligned.
  - Otherwise 0; forced 0 while reset is high.
- **Store lanes:**
  - byte: wstrb=1<<off, wdata={4{sd[7:0]}}.
  - half: wstrb=off[1]?1100:0011, wdata={2{sd[15:0]}}.
  - word: wstrb=1111, wdata=sd.
- **Load extract:**
  - byte: rdata[8*off+:8].
  - half: rdata[16*off[1]+:16].
  - word: full word.
  - Extend to 32 bits per load_unsigned.
- lu_output_out holds its value between loads; stores never change it.
- **Reset mid-operation:** the FSM returns to IDLE and all outputs return to their reset values on the next edge. A late response is ignored.

## Timing
- Reset values: dmem_req_valid_out=0, dmem_addr_out=0, dmem_we_out=0, dmem_wstrb_out=0, dmem_wdata_out=0, lu_output_out=0, lu_valid_out=0, misaligned_out=0, FSM=IDLE.
- Minimum load, with ready=1 in REQ and the response in the next cycle:
  - Accept (IDLE, C0) → REQ (C1) → RSP (C2) → DONE (C3).
  - Result is visible in C3; stall_out is high in C0–C2.
- Minimum store: IDLE (C0) → REQ (C1) → DONE (C2); stall_out is high in C0–C1.
- Each REQ cycle without ready, and each RSP cycle without rsp_valid, adds one cycle.
- No request is issued while in DONE. The next instruction is sampled in IDLE.

## Structure
- Package lsu_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - FSM state encoding;
  - wb_mux_sel constant WB_LU=3'b001 (shared with the write-back mux).
- Sub-module load_align_ext: combinational extract and extend (rdata, offset, size, unsigned → 32-bit result).

## Test plan
- Word store to 0x100, data 0xDEADBEEF, ready=1 → wstrb=1111, addr 0x100, we=1; stall high for 2 cycles; lu_valid pulses in C2.
- Byte store of 0x000000A5 to 0x203 → addr 0x200, wstrb=1000, wdata=0xA5A5A5A5.
- Signed byte load from 0x102, rdata 0x0080FF00 → lu_output 0xFFFFFF80; the same with unsigned → 0x00000080.
- Half load from 0x102, rdata 0x8001_1234, ready held low 3 cycles → stall extends 3 cycles; lu_output 0xFFFF8001.
- Word load from 0x101 → misaligned_out pulses once; dmem_req_valid_out stays 0; stall_out=0.
- Reset asserted in RSP, then rsp_valid arrives → FSM is IDLE, lu_output stays 0, no lu_valid pulse.
